// File: rtl/bin_to_bcd_seq_if.sv
// Handshake/result bundle between the display register and the BCD converter.
// master: drives in/start, reads bcd/ndigits/busy/done. slave: the converter.
interface bin_to_bcd_seq_if #(
    parameter int N      = 10,
    parameter int DIGITS = 4
);
    localparam int NDW = $clog2(DIGITS + 1);

    logic [N-1:0]          in;
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic [NDW-1:0]        ndigits;
    logic                  busy;
    logic                  done;

    modport master (
        output in,
        output start,
        input  bcd,
        input  ndigits,
        input  busy,
        input  done
    );

    modport slave (
        input  in,
        input  start,
        output bcd,
        output ndigits,
        output busy,
        output done
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Ports: clk, reset (async, active-high), bus (slave: in/start -> bcd/ndigits/busy/done).
module bin_to_bcd_seq #(
    parameter int N      = 10,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int W   = 4 * DIGITS;
    localparam int CW  = $clog2(N + 1);
    localparam int NDW = $clog2(DIGITS + 1);

    function automatic longint pow10(input int d);
        longint p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    localparam longint MAXV = (longint'(1) << N) - 1;
    localparam longint CAP  = pow10(DIGITS);

    // DIGITS must cover the full input range, otherwise digits overflow.
    if (!(CAP > MAXV)) begin : g_bad_params
        $error("bin_to_bcd_seq: DIGITS too small for N");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [N-1:0]    sr;
    logic [W-1:0]    acc;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    bcd_q;
    logic [NDW-1:0]  nd_q;
    logic            busy_q;
    logic            done_q;

    logic [W-1:0]    adj;
    logic [W-1:0]    acc_next;
    logic [NDW-1:0]  nd_next;

    // Add-3 per digit, no carry between digits.
    always_comb begin
        adj = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
        acc_next = {adj[W-2:0], sr[N-1]};
    end

    // Count of significant digits; all-zero still shows one digit.
    always_comb begin
        nd_next = NDW'(1);
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_next[4*k +: 4] != 4'd0)
                nd_next = NDW'(k + 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sr     <= '0;
            acc    <= '0;
            cnt    <= '0;
            bcd_q  <= '0;
            nd_q   <= NDW'(1);
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr     <= bus.in;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    sr  <= {sr[N-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        bcd_q  <= acc_next;
                        nd_q   <= nd_next;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bcd     = bcd_q;
    assign bus.ndigits = nd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: expected digits queued at start,
// checked on each done pulse.
module tb_bin_to_bcd_seq;
    localparam int N      = 10;
    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] bcd;
        logic [2:0]  nd;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    exp_t sb[$];

    bin_to_bcd_seq_if #(.N(N), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.N(N), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_of(input int v);
        exp_t e;
        int   t;
        t = v;
        e.bcd = '0;
        for (int k = 0; k < DIGITS; k++) begin
            e.bcd[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        if (v < 10)        e.nd = 3'd1;
        else if (v < 100)  e.nd = 3'd2;
        else if (v < 1000) e.nd = 3'd3;
        else               e.nd = 3'd4;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("bcd", 32'(bus.bcd), 32'(e.bcd));
                check("ndigits", 32'(bus.ndigits), 32'(e.nd));
            end
        end
    end

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.done), 32'd1);
    endtask

    task automatic convert(input int v);
        int lat;
        int bc;
        @(negedge clk);
        bus.in    = 10'(v);
        bus.start = 1'b1;
        sb.push_back(model_of(v));
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        bc  = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) bc++;
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat - 1), 32'(N));
        check("busy_cycles", 32'(bc), 32'(N));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        int n0;
        int c1;
        int c2;
        int c3;
        bus.in    = '0;
        bus.start = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_bcd", 32'(bus.bcd), 32'h0);
        check("rst_nd", 32'(bus.ndigits), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);

        convert(1023);
        check("full_hold", 32'(bus.bcd), 32'h1023);
        convert(0);
        convert(7);
        convert(250);

        // start/in changes while busy are ignored
        n0 = done_cnt;
        @(negedge clk);
        bus.in    = 10'd512;
        bus.start = 1'b1;
        sb.push_back(model_of(512));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.in    = 10'd99;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("busy_ign_done");
        repeat (20) @(negedge clk);
        check("busy_ign_count", 32'(done_cnt - n0), 32'd1);
        check("busy_ign_hold", 32'(bus.bcd), 32'h0512);

        // reset mid-conversion
        convert(42);
        check("hold_42", 32'(bus.bcd), 32'h0042);
        @(negedge clk);
        bus.in    = 10'd999;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_bcd", 32'(bus.bcd), 32'h0);
        check("mid_rst_nd", 32'(bus.ndigits), 32'd1);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n0 = done_cnt;
        repeat (20) @(negedge clk);
        check("mid_rst_nodone", 32'(done_cnt - n0), 32'd0);

        // back-to-back with start held high
        @(negedge clk);
        bus.in    = 10'd1;
        bus.start = 1'b1;
        sb.push_back(model_of(1));
        @(negedge clk);
        wait_done("b2b_done1");
        c1 = cyc;
        bus.in = 10'd2;
        sb.push_back(model_of(2));
        @(negedge clk);
        wait_done("b2b_done2");
        c2 = cyc;
        bus.in = 10'd3;
        sb.push_back(model_of(3));
        @(negedge clk);
        wait_done("b2b_done3");
        c3 = cyc;
        bus.start = 1'b0;
        check("b2b_period12", 32'(c2 - c1), 32'(N + 1));
        check("b2b_period23", 32'(c3 - c2), 32'(N + 1));
        repeat (15) @(negedge clk);

        for (int v = 0; v < (1 << N); v++) convert(v);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
